dieu_khien_ngay_thang_nam: RTL

//   Date controller for the century clock: holds day/month/year as 2-digit BCD.

---
 rtl/dieu_khien_ngay_thang_nam.sv | 139 +++++++++++++
 1 files changed

// File: rtl/dieu_khien_ngay_thang_nam.sv
// Date controller: BCD day/month/year with day-tick advance, button-driven field
// editing and per-field blink flags for the date display.
module dieu_khien_ngay_thang_nam #(
  parameter logic [7:0] INIT_NGAY  = 8'h01,
  parameter logic [7:0] INIT_THANG = 8'h01,
  parameter logic [7:0] INIT_NAM   = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_ngay,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       nhay,
  output logic [7:0] ngay,
  output logic [7:0] thang,
  output logic [7:0] nam,
  output logic       tat_ngay,
  output logic       tat_thang,
  output logic       tat_nam,
  output logic [1:0] che_do
);

  localparam logic [1:0] StRun      = 2'd0;
  localparam logic [1:0] StSetNgay  = 2'd1;
  localparam logic [1:0] StSetThang = 2'd2;
  localparam logic [1:0] StSetNam   = 2'd3;

  logic [7:0] ngay_q, ngay_d, thang_q, thang_d, nam_q, nam_d;
  logic [1:0] state_q, state_d;
  logic       phase_q, phase_d;
  logic       tat_ngay_q, tat_ngay_d, tat_thang_q, tat_thang_d, tat_nam_q, tat_nam_d;
  logic       nam_nhuan;
  logic [7:0] ngay_max;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [3:0] tens;
    tens = v[7:4] + 4'd1;
    if (v[3:0] == 4'd9) return {tens, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Leap test on BCD digits: year value divisible by 4.
  always_comb begin
    if (!nam_q[4]) nam_nhuan = (nam_q[3:0] inside {4'd0, 4'd4, 4'd8});
    else           nam_nhuan = (nam_q[3:0] inside {4'd2, 4'd6});
  end

  always_comb begin
    case (thang_q)
      8'h02:                      ngay_max = nam_nhuan ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: ngay_max = 8'h30;
      default:                    ngay_max = 8'h31;
    endcase
  end

  always_comb begin
    ngay_d  = ngay_q;
    thang_d = thang_q;
    nam_d   = nam_q;
    state_d = state_q;
    phase_d = phase_q;
    case (state_q)
      StRun: begin
        if (tick_ngay) begin
          if (ngay_q == ngay_max) begin
            ngay_d = 8'h01;
            if (thang_q == 8'h12) begin
              thang_d = 8'h01;
              nam_d   = (nam_q == 8'h99) ? 8'h00 : bcd_inc(nam_q);
            end else begin
              thang_d = bcd_inc(thang_q);
            end
          end else begin
            ngay_d = bcd_inc(ngay_q);
          end
        end
        if (btn_mode) begin
          state_d = StSetNgay;
          phase_d = 1'b0;
        end
      end
      default: begin
        if (btn_mode) begin
          phase_d = 1'b0;
          if (state_q == StSetNam) begin
            state_d = StRun;
            // BCD ordering matches numeric ordering, so a plain compare clamps correctly.
            if (ngay_q > ngay_max) ngay_d = ngay_max;
          end else begin
            state_d = state_q + 2'd1;
          end
        end else begin
          if (btn_up) begin
            case (state_q)
              StSetNgay:  ngay_d  = (ngay_q == ngay_max) ? 8'h01 : bcd_inc(ngay_q);
              StSetThang: thang_d = (thang_q == 8'h12) ? 8'h01 : bcd_inc(thang_q);
              default:    nam_d   = (nam_q == 8'h99) ? 8'h00 : bcd_inc(nam_q);
            endcase
          end
          if (nhay) phase_d = ~phase_q;
        end
      end
    endcase
    tat_ngay_d  = (state_d == StSetNgay)  && phase_d;
    tat_thang_d = (state_d == StSetThang) && phase_d;
    tat_nam_d   = (state_d == StSetNam)   && phase_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ngay_q      <= INIT_NGAY;
      thang_q     <= INIT_THANG;
      nam_q       <= INIT_NAM;
      state_q     <= StRun;
      phase_q     <= 1'b0;
      tat_ngay_q  <= 1'b0;
      tat_thang_q <= 1'b0;
      tat_nam_q   <= 1'b0;
    end else begin
      ngay_q      <= ngay_d;
      thang_q     <= thang_d;
      nam_q       <= nam_d;
      state_q     <= state_d;
      phase_q     <= phase_d;
      tat_ngay_q  <= tat_ngay_d;
      tat_thang_q <= tat_thang_d;
      tat_nam_q   <= tat_nam_d;
    end
  end

  assign ngay      = ngay_q;
  assign thang     = thang_q;
  assign nam       = nam_q;
  assign tat_ngay  = tat_ngay_q;
  assign tat_thang = tat_thang_q;
  assign tat_nam   = tat_nam_q;
  assign che_do    = state_q;

endmodule
